// File: rtl/axis_mon_mc_pkg.sv
// Shared types, widths and helpers for the multi-channel AXI4-Stream monitor.
package axis_mon_mc_pkg;

  localparam int CNT_W = 64;
  localparam int TS_W = 32;
  localparam logic [TS_W-1:0] LAT_MIN_INIT = '1;
  // Widest tkeep the popcount helper handles (DWIDTH up to 2048 bits).
  localparam int KEEP_MAX_W = 256;

  typedef struct packed {
    logic [CNT_W-1:0] pkt;
    logic [CNT_W-1:0] bytes;
    logic [CNT_W-1:0] elapsed;
  } dir_stats_t;

  typedef struct packed {
    dir_stats_t       tx;
    dir_stats_t       rx;
    logic [CNT_W-1:0] lat_sum;
    logic [CNT_W-1:0] lat_cnt;
    logic [TS_W-1:0]  lat_min;
    logic [TS_W-1:0]  lat_max;
  } ch_stats_t;

  function automatic logic [CNT_W-1:0] popcount(input logic [KEEP_MAX_W-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < KEEP_MAX_W; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

  function automatic ch_stats_t stats_init();
    ch_stats_t s;
    s = '0;
    s.lat_min = LAT_MIN_INIT;
    return s;
  endfunction

endpackage

// File: rtl/axis_mon_ch.sv
// One monitored TX/RX pair: beat/packet/byte/elapsed counters, timestamp FIFO
// and latency statistics. stats_next exposes next-state values for snapshot capture.
module axis_mon_ch
  import axis_mon_mc_pkg::*;
#(
  parameter int DWIDTH    = 64,
  parameter int HAS_READY = 1,
  parameter int HAS_KEEP  = 1,
  parameter int HAS_LAST  = 1,
  parameter int TS_DEPTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic [CNT_W-1:0]      time_cnt,
  input  logic                  tx_tvalid,
  input  logic                  tx_tready,
  input  logic                  tx_tlast,
  input  logic [DWIDTH/8-1:0]   tx_tkeep,
  input  logic                  rx_tvalid,
  input  logic                  rx_tready,
  input  logic                  rx_tlast,
  input  logic [DWIDTH/8-1:0]   rx_tkeep,
  output ch_stats_t             stats_next,
  output logic                  ts_ovf,
  output logic                  ts_unf
);

  localparam int KW = DWIDTH / 8;
  localparam int PW = $clog2(TS_DEPTH);

  logic [1:0]        valid, ready, last, beat, pkt_end;
  logic [KW-1:0]     keep [2];
  logic [CNT_W-1:0]  beat_bytes [2];
  logic [CNT_W-1:0]  pkt_q [2], pkt_d [2];
  logic [CNT_W-1:0]  bytes_q [2], bytes_d [2];
  logic [CNT_W-1:0]  first_ts_q [2], first_ts_d [2];
  logic [CNT_W-1:0]  last_ts_q [2], last_ts_d [2];
  logic [CNT_W-1:0]  elapsed [2];
  logic [1:0]        seen_q, seen_d;

  assign valid   = {rx_tvalid, tx_tvalid};
  assign ready   = {rx_tready, tx_tready};
  assign last    = {rx_tlast, tx_tlast};
  assign keep[0] = tx_tkeep;
  assign keep[1] = rx_tkeep;

  // Index 0 is the TX tap, index 1 the RX tap.
  always_comb begin
    for (int d = 0; d < 2; d++) begin
      beat[d]       = valid[d] & (ready[d] | (HAS_READY == 0));
      pkt_end[d]    = beat[d] & (last[d] | (HAS_LAST == 0));
      beat_bytes[d] = (HAS_KEEP != 0) ? popcount(KEEP_MAX_W'(keep[d])) : CNT_W'(KW);
      pkt_d[d]      = pkt_q[d] + CNT_W'(pkt_end[d]);
      bytes_d[d]    = beat[d] ? bytes_q[d] + beat_bytes[d] : bytes_q[d];
      seen_d[d]     = seen_q[d] | beat[d];
      first_ts_d[d] = (beat[d] && !seen_q[d]) ? time_cnt : first_ts_q[d];
      last_ts_d[d]  = beat[d] ? time_cnt : last_ts_q[d];
      elapsed[d]    = seen_d[d] ? last_ts_d[d] - first_ts_d[d] + CNT_W'(1) : '0;
    end
  end

  logic [TS_W-1:0]  mem_q [TS_DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             push, pop, empty, full, bypass, do_wr, do_rd;
  logic             lat_valid;
  logic [TS_W-1:0]  now_ts, lat_val;
  logic             ts_ovf_q, ts_ovf_d, ts_unf_q, ts_unf_d;
  logic [CNT_W-1:0] lat_sum_q, lat_sum_d, lat_cnt_q, lat_cnt_d;
  logic [TS_W-1:0]  lat_min_q, lat_min_d, lat_max_q, lat_max_d;

  // A push/pop pair on an empty FIFO bypasses storage and yields latency 0.
  always_comb begin
    push      = pkt_end[0];
    pop       = pkt_end[1];
    now_ts    = time_cnt[TS_W-1:0];
    empty     = (count_q == '0);
    full      = (count_q == (PW+1)'(TS_DEPTH));
    bypass    = push & pop & empty;
    do_wr     = push & !bypass & (!full | pop);
    do_rd     = pop & !empty;
    lat_valid = bypass | do_rd;
    lat_val   = do_rd ? now_ts - mem_q[rd_ptr_q] : '0;
    wr_ptr_d  = do_wr ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = do_rd ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d   = count_q + (PW+1)'(do_wr) - (PW+1)'(do_rd);
    ts_ovf_d  = ts_ovf_q | (push & full & !pop);
    ts_unf_d  = ts_unf_q | (pop & empty & !push);
    lat_sum_d = lat_valid ? lat_sum_q + CNT_W'(lat_val) : lat_sum_q;
    lat_cnt_d = lat_cnt_q + CNT_W'(lat_valid);
    lat_min_d = (lat_valid && (lat_val < lat_min_q)) ? lat_val : lat_min_q;
    lat_max_d = (lat_valid && (lat_val > lat_max_q)) ? lat_val : lat_max_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      for (int d = 0; d < 2; d++) begin
        pkt_q[d]      <= '0;
        bytes_q[d]    <= '0;
        first_ts_q[d] <= '0;
        last_ts_q[d]  <= '0;
      end
      seen_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ts_ovf_q  <= 1'b0;
      ts_unf_q  <= 1'b0;
      lat_sum_q <= '0;
      lat_cnt_q <= '0;
      lat_min_q <= LAT_MIN_INIT;
      lat_max_q <= '0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        pkt_q[d]      <= pkt_d[d];
        bytes_q[d]    <= bytes_d[d];
        first_ts_q[d] <= first_ts_d[d];
        last_ts_q[d]  <= last_ts_d[d];
      end
      seen_q    <= seen_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ts_ovf_q  <= ts_ovf_d;
      ts_unf_q  <= ts_unf_d;
      lat_sum_q <= lat_sum_d;
      lat_cnt_q <= lat_cnt_d;
      lat_min_q <= lat_min_d;
      lat_max_q <= lat_max_d;
    end
  end

  // Storage needs no reset; pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= now_ts;
    end
  end

  always_comb begin
    stats_next            = '0;
    stats_next.tx.pkt     = pkt_d[0];
    stats_next.tx.bytes   = bytes_d[0];
    stats_next.tx.elapsed = elapsed[0];
    stats_next.rx.pkt     = pkt_d[1];
    stats_next.rx.bytes   = bytes_d[1];
    stats_next.rx.elapsed = elapsed[1];
    stats_next.lat_sum    = lat_sum_d;
    stats_next.lat_cnt    = lat_cnt_d;
    stats_next.lat_min    = lat_min_d;
    stats_next.lat_max    = lat_max_d;
  end

  assign ts_ovf = ts_ovf_q;
  assign ts_unf = ts_unf_q;

endmodule

// File: rtl/axis_mon_mc.sv
// Multi-channel AXI4-Stream traffic monitor: free-running time base, per-channel
// monitors and coherent snapshot registers for every reported statistic.
module axis_mon_mc
  import axis_mon_mc_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int DWIDTH    = 64,
  parameter int HAS_READY = 1,
  parameter int HAS_KEEP  = 1,
  parameter int HAS_LAST  = 1,
  parameter int TS_DEPTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         snap,
  input  logic [NUM_CH-1:0]            tx_tvalid,
  input  logic [NUM_CH-1:0]            tx_tready,
  input  logic [NUM_CH-1:0]            tx_tlast,
  input  logic [NUM_CH*DWIDTH/8-1:0]   tx_tkeep,
  input  logic [NUM_CH-1:0]            rx_tvalid,
  input  logic [NUM_CH-1:0]            rx_tready,
  input  logic [NUM_CH-1:0]            rx_tlast,
  input  logic [NUM_CH*DWIDTH/8-1:0]   rx_tkeep,
  output logic                         snap_done,
  output logic [CNT_W-1:0]             time_cnt,
  output logic [NUM_CH*CNT_W-1:0]      tx_pkt_cnt,
  output logic [NUM_CH*CNT_W-1:0]      tx_bytes,
  output logic [NUM_CH*CNT_W-1:0]      tx_elapsed,
  output logic [NUM_CH*CNT_W-1:0]      rx_pkt_cnt,
  output logic [NUM_CH*CNT_W-1:0]      rx_bytes,
  output logic [NUM_CH*CNT_W-1:0]      rx_elapsed,
  output logic [NUM_CH*CNT_W-1:0]      lat_sum,
  output logic [NUM_CH*CNT_W-1:0]      lat_cnt,
  output logic [NUM_CH*TS_W-1:0]       lat_min,
  output logic [NUM_CH*TS_W-1:0]       lat_max,
  output logic [NUM_CH-1:0]            ts_ovf,
  output logic [NUM_CH-1:0]            ts_unf
);

  localparam int KW = DWIDTH / 8;

  logic [CNT_W-1:0] time_cnt_q, time_cnt_d;
  logic             snap_done_q, snap_done_d;
  ch_stats_t        live [NUM_CH];
  ch_stats_t        snap_q [NUM_CH];
  ch_stats_t        snap_d [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    axis_mon_ch #(
      .DWIDTH    (DWIDTH),
      .HAS_READY (HAS_READY),
      .HAS_KEEP  (HAS_KEEP),
      .HAS_LAST  (HAS_LAST),
      .TS_DEPTH  (TS_DEPTH)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .time_cnt   (time_cnt_q),
      .tx_tvalid  (tx_tvalid[c]),
      .tx_tready  (tx_tready[c]),
      .tx_tlast   (tx_tlast[c]),
      .tx_tkeep   (tx_tkeep[c*KW +: KW]),
      .rx_tvalid  (rx_tvalid[c]),
      .rx_tready  (rx_tready[c]),
      .rx_tlast   (rx_tlast[c]),
      .rx_tkeep   (rx_tkeep[c*KW +: KW]),
      .stats_next (live[c]),
      .ts_ovf     (ts_ovf[c]),
      .ts_unf     (ts_unf[c])
    );

    assign tx_pkt_cnt[c*CNT_W +: CNT_W] = snap_q[c].tx.pkt;
    assign tx_bytes[c*CNT_W +: CNT_W]   = snap_q[c].tx.bytes;
    assign tx_elapsed[c*CNT_W +: CNT_W] = snap_q[c].tx.elapsed;
    assign rx_pkt_cnt[c*CNT_W +: CNT_W] = snap_q[c].rx.pkt;
    assign rx_bytes[c*CNT_W +: CNT_W]   = snap_q[c].rx.bytes;
    assign rx_elapsed[c*CNT_W +: CNT_W] = snap_q[c].rx.elapsed;
    assign lat_sum[c*CNT_W +: CNT_W]    = snap_q[c].lat_sum;
    assign lat_cnt[c*CNT_W +: CNT_W]    = snap_q[c].lat_cnt;
    assign lat_min[c*TS_W +: TS_W]      = snap_q[c].lat_min;
    assign lat_max[c*TS_W +: TS_W]      = snap_q[c].lat_max;
  end

  // Snapshot takes next-state values so events in the snap cycle are included.
  always_comb begin
    time_cnt_d  = time_cnt_q + CNT_W'(1);
    snap_done_d = snap;
    for (int c = 0; c < NUM_CH; c++) begin
      snap_d[c] = snap ? live[c] : snap_q[c];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      time_cnt_q  <= '0;
      snap_done_q <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        snap_q[c] <= stats_init();
      end
    end else begin
      time_cnt_q  <= time_cnt_d;
      snap_done_q <= snap_done_d;
      for (int c = 0; c < NUM_CH; c++) begin
        snap_q[c] <= snap_d[c];
      end
    end
  end

  assign time_cnt  = time_cnt_q;
  assign snap_done = snap_done_q;

endmodule

// File: tb/tb_axis_mon_mc.sv
// Directed self-checking bench for axis_mon_mc with hand-computed expectations.
module tb_axis_mon_mc;

  logic         clk;
  logic         rst_n, clear, snap;
  logic [3:0]   tx_tvalid, tx_tready, tx_tlast;
  logic [3:0]   rx_tvalid, rx_tready, rx_tlast;
  logic [31:0]  tx_tkeep, rx_tkeep;
  logic         snap_done;
  logic [63:0]  time_cnt;
  logic [255:0] tx_pkt_cnt, tx_bytes, tx_elapsed;
  logic [255:0] rx_pkt_cnt, rx_bytes, rx_elapsed;
  logic [255:0] lat_sum, lat_cnt;
  logic [127:0] lat_min, lat_max;
  logic [3:0]   ts_ovf, ts_unf;

  int checks = 0;
  int passed = 0;

  axis_mon_mc #(
    .NUM_CH(4), .DWIDTH(64), .HAS_READY(1), .HAS_KEEP(1), .HAS_LAST(1), .TS_DEPTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .snap(snap),
    .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tlast(tx_tlast), .tx_tkeep(tx_tkeep),
    .rx_tvalid(rx_tvalid), .rx_tready(rx_tready), .rx_tlast(rx_tlast), .rx_tkeep(rx_tkeep),
    .snap_done(snap_done), .time_cnt(time_cnt),
    .tx_pkt_cnt(tx_pkt_cnt), .tx_bytes(tx_bytes), .tx_elapsed(tx_elapsed),
    .rx_pkt_cnt(rx_pkt_cnt), .rx_bytes(rx_bytes), .rx_elapsed(rx_elapsed),
    .lat_sum(lat_sum), .lat_cnt(lat_cnt), .lat_min(lat_min), .lat_max(lat_max),
    .ts_ovf(ts_ovf), .ts_unf(ts_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tx_tvalid = '0; tx_tlast = '0; tx_tready = '1; tx_tkeep = '1;
    rx_tvalid = '0; rx_tlast = '0; rx_tready = '1; rx_tkeep = '1;
  endtask

  task automatic do_snap();
    snap = 1'b1;
    tick();
    snap = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0; clear = 1'b0; snap = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    do_snap();
    checks++; if (time_cnt !== 64'd2) $display("[TB] FAIL rst_time_cnt got %0d exp 2", time_cnt); else passed++;
    checks++; if (snap_done !== 1'b1) $display("[TB] FAIL rst_snap_done got %0b exp 1", snap_done); else passed++;
    checks++; if (tx_pkt_cnt[0 +: 64] !== 64'd0) $display("[TB] FAIL rst_tx_pkt0 got %0d exp 0", tx_pkt_cnt[0 +: 64]); else passed++;
    checks++; if (rx_bytes[192 +: 64] !== 64'd0) $display("[TB] FAIL rst_rx_bytes3 got %0d exp 0", rx_bytes[192 +: 64]); else passed++;
    checks++; if (tx_elapsed[0 +: 64] !== 64'd0) $display("[TB] FAIL rst_tx_elapsed0 got %0d exp 0", tx_elapsed[0 +: 64]); else passed++;
    checks++; if (lat_min[64 +: 32] !== 32'hFFFFFFFF) $display("[TB] FAIL rst_lat_min2 got %h exp ffffffff", lat_min[64 +: 32]); else passed++;
    checks++; if (lat_max[32 +: 32] !== 32'd0) $display("[TB] FAIL rst_lat_max1 got %0d exp 0", lat_max[32 +: 32]); else passed++;
    checks++; if (ts_ovf !== 4'b0 || ts_unf !== 4'b0) $display("[TB] FAIL rst_flags got ovf=%b unf=%b exp 0000", ts_ovf, ts_unf); else passed++;
    tick();
    checks++; if (snap_done !== 1'b0) $display("[TB] FAIL rst_snap_done_pulse got %0b exp 0", snap_done); else passed++;
  endtask

  task automatic test_loopback();
    for (int i = 0; i < 22; i++) begin
      tx_tvalid[0] = (i < 12);
      tx_tlast[0]  = (i < 12) && (i % 4 == 3);
      rx_tvalid[0] = (i >= 10);
      rx_tlast[0]  = (i >= 10) && ((i - 10) % 4 == 3);
      tick();
    end
    idle();
    tick();
    do_snap();
    checks++; if (tx_pkt_cnt[0 +: 64] !== 64'd3) $display("[TB] FAIL lb_tx_pkt got %0d exp 3", tx_pkt_cnt[0 +: 64]); else passed++;
    checks++; if (rx_pkt_cnt[0 +: 64] !== 64'd3) $display("[TB] FAIL lb_rx_pkt got %0d exp 3", rx_pkt_cnt[0 +: 64]); else passed++;
    checks++; if (tx_bytes[0 +: 64] !== 64'd96) $display("[TB] FAIL lb_tx_bytes got %0d exp 96", tx_bytes[0 +: 64]); else passed++;
    checks++; if (rx_bytes[0 +: 64] !== 64'd96) $display("[TB] FAIL lb_rx_bytes got %0d exp 96", rx_bytes[0 +: 64]); else passed++;
    checks++; if (tx_elapsed[0 +: 64] !== 64'd12) $display("[TB] FAIL lb_tx_elapsed got %0d exp 12", tx_elapsed[0 +: 64]); else passed++;
    checks++; if (rx_elapsed[0 +: 64] !== 64'd12) $display("[TB] FAIL lb_rx_elapsed got %0d exp 12", rx_elapsed[0 +: 64]); else passed++;
    checks++; if (lat_cnt[0 +: 64] !== 64'd3) $display("[TB] FAIL lb_lat_cnt got %0d exp 3", lat_cnt[0 +: 64]); else passed++;
    checks++; if (lat_sum[0 +: 64] !== 64'd30) $display("[TB] FAIL lb_lat_sum got %0d exp 30", lat_sum[0 +: 64]); else passed++;
    checks++; if (lat_min[0 +: 32] !== 32'd10) $display("[TB] FAIL lb_lat_min got %0d exp 10", lat_min[0 +: 32]); else passed++;
    checks++; if (lat_max[0 +: 32] !== 32'd10) $display("[TB] FAIL lb_lat_max got %0d exp 10", lat_max[0 +: 32]); else passed++;
  endtask

  task automatic test_ready_keep();
    for (int i = 0; i < 7; i++) begin
      tx_tvalid[1]     = 1'b1;
      tx_tready[1]     = (i % 2 == 0);
      tx_tlast[1]      = (i >= 5);
      tx_tkeep[15:8]   = (i >= 5) ? 8'h0F : 8'hFF;
      tick();
    end
    idle();
    tick();
    do_snap();
    checks++; if (tx_pkt_cnt[64 +: 64] !== 64'd1) $display("[TB] FAIL rk_tx_pkt got %0d exp 1", tx_pkt_cnt[64 +: 64]); else passed++;
    checks++; if (tx_bytes[64 +: 64] !== 64'd28) $display("[TB] FAIL rk_tx_bytes got %0d exp 28", tx_bytes[64 +: 64]); else passed++;
    checks++; if (tx_elapsed[64 +: 64] !== 64'd7) $display("[TB] FAIL rk_tx_elapsed got %0d exp 7", tx_elapsed[64 +: 64]); else passed++;
    checks++; if (rx_pkt_cnt[64 +: 64] !== 64'd0) $display("[TB] FAIL rk_rx_pkt got %0d exp 0", rx_pkt_cnt[64 +: 64]); else passed++;
    checks++; if (lat_cnt[64 +: 64] !== 64'd0) $display("[TB] FAIL rk_lat_cnt got %0d exp 0", lat_cnt[64 +: 64]); else passed++;
    checks++; if (tx_pkt_cnt[0 +: 64] !== 64'd3) $display("[TB] FAIL rk_ch0_kept got %0d exp 3", tx_pkt_cnt[0 +: 64]); else passed++;
  endtask

  task automatic test_overflow_underflow();
    for (int i = 0; i < 34; i++) begin
      tx_tvalid[2] = (i <= 16);
      tx_tlast[2]  = (i <= 16);
      rx_tvalid[2] = (i >= 17);
      rx_tlast[2]  = (i >= 17);
      tick();
      if (i == 15) begin
        checks++; if (ts_ovf !== 4'b0000) $display("[TB] FAIL ovf_before_full got %b exp 0000", ts_ovf); else passed++;
      end
      if (i == 16) begin
        checks++; if (ts_ovf !== 4'b0100) $display("[TB] FAIL ovf_set got %b exp 0100", ts_ovf); else passed++;
      end
      if (i == 32) begin
        checks++; if (ts_unf !== 4'b0000) $display("[TB] FAIL unf_after_drain got %b exp 0000", ts_unf); else passed++;
      end
      if (i == 33) begin
        checks++; if (ts_unf !== 4'b0100) $display("[TB] FAIL unf_set got %b exp 0100", ts_unf); else passed++;
      end
    end
    idle();
    tick();
    do_snap();
    checks++; if (tx_pkt_cnt[128 +: 64] !== 64'd17) $display("[TB] FAIL ou_tx_pkt got %0d exp 17", tx_pkt_cnt[128 +: 64]); else passed++;
    checks++; if (rx_pkt_cnt[128 +: 64] !== 64'd17) $display("[TB] FAIL ou_rx_pkt got %0d exp 17", rx_pkt_cnt[128 +: 64]); else passed++;
    checks++; if (rx_bytes[128 +: 64] !== 64'd136) $display("[TB] FAIL ou_rx_bytes got %0d exp 136", rx_bytes[128 +: 64]); else passed++;
    checks++; if (rx_elapsed[128 +: 64] !== 64'd17) $display("[TB] FAIL ou_rx_elapsed got %0d exp 17", rx_elapsed[128 +: 64]); else passed++;
    checks++; if (lat_cnt[128 +: 64] !== 64'd16) $display("[TB] FAIL ou_lat_cnt got %0d exp 16", lat_cnt[128 +: 64]); else passed++;
    checks++; if (lat_sum[128 +: 64] !== 64'd272) $display("[TB] FAIL ou_lat_sum got %0d exp 272", lat_sum[128 +: 64]); else passed++;
    checks++; if (lat_min[64 +: 32] !== 32'd17) $display("[TB] FAIL ou_lat_min got %0d exp 17", lat_min[64 +: 32]); else passed++;
    checks++; if (lat_max[64 +: 32] !== 32'd17) $display("[TB] FAIL ou_lat_max got %0d exp 17", lat_max[64 +: 32]); else passed++;
    checks++; if (lat_cnt[0 +: 64] !== 64'd3) $display("[TB] FAIL ou_ch0_kept got %0d exp 3", lat_cnt[0 +: 64]); else passed++;
  endtask

  task automatic test_bypass();
    tx_tvalid[3] = 1'b1; tx_tlast[3] = 1'b1;
    rx_tvalid[3] = 1'b1; rx_tlast[3] = 1'b1;
    tick();
    idle();
    tick();
    do_snap();
    checks++; if (lat_cnt[192 +: 64] !== 64'd1) $display("[TB] FAIL bp_lat_cnt got %0d exp 1", lat_cnt[192 +: 64]); else passed++;
    checks++; if (lat_sum[192 +: 64] !== 64'd0) $display("[TB] FAIL bp_lat_sum got %0d exp 0", lat_sum[192 +: 64]); else passed++;
    checks++; if (lat_min[96 +: 32] !== 32'd0) $display("[TB] FAIL bp_lat_min got %0d exp 0", lat_min[96 +: 32]); else passed++;
    checks++; if (lat_max[96 +: 32] !== 32'd0) $display("[TB] FAIL bp_lat_max got %0d exp 0", lat_max[96 +: 32]); else passed++;
    checks++; if (ts_unf !== 4'b0100 || ts_ovf !== 4'b0100) $display("[TB] FAIL bp_flags got ovf=%b unf=%b exp 0100", ts_ovf, ts_unf); else passed++;
  endtask

  task automatic test_clear_snap();
    for (int i = 0; i < 3; i++) begin
      tx_tvalid[0] = 1'b1;
      tx_tlast[0]  = (i == 1);
      tick();
    end
    clear = 1'b1;
    snap  = 1'b1;
    tick();
    clear = 1'b0;
    snap  = 1'b0;
    idle();
    checks++; if (time_cnt !== 64'd0) $display("[TB] FAIL cl_time_cnt got %0d exp 0", time_cnt); else passed++;
    checks++; if (snap_done !== 1'b0) $display("[TB] FAIL cl_snap_done got %0b exp 0", snap_done); else passed++;
    checks++; if (tx_pkt_cnt[0 +: 64] !== 64'd0) $display("[TB] FAIL cl_tx_pkt0 got %0d exp 0", tx_pkt_cnt[0 +: 64]); else passed++;
    checks++; if (tx_bytes[64 +: 64] !== 64'd0) $display("[TB] FAIL cl_tx_bytes1 got %0d exp 0", tx_bytes[64 +: 64]); else passed++;
    checks++; if (lat_cnt[128 +: 64] !== 64'd0) $display("[TB] FAIL cl_lat_cnt2 got %0d exp 0", lat_cnt[128 +: 64]); else passed++;
    checks++; if (lat_min[64 +: 32] !== 32'hFFFFFFFF) $display("[TB] FAIL cl_lat_min2 got %h exp ffffffff", lat_min[64 +: 32]); else passed++;
    checks++; if (ts_ovf !== 4'b0 || ts_unf !== 4'b0) $display("[TB] FAIL cl_flags got ovf=%b unf=%b exp 0000", ts_ovf, ts_unf); else passed++;
    for (int i = 0; i < 4; i++) begin
      tx_tvalid[0] = 1'b1;
      tx_tlast[0]  = (i == 1) || (i == 3);
      tick();
    end
    idle();
    tick();
    do_snap();
    checks++; if (tx_pkt_cnt[0 +: 64] !== 64'd2) $display("[TB] FAIL pc_tx_pkt got %0d exp 2", tx_pkt_cnt[0 +: 64]); else passed++;
    checks++; if (tx_bytes[0 +: 64] !== 64'd32) $display("[TB] FAIL pc_tx_bytes got %0d exp 32", tx_bytes[0 +: 64]); else passed++;
    checks++; if (tx_elapsed[0 +: 64] !== 64'd4) $display("[TB] FAIL pc_tx_elapsed got %0d exp 4", tx_elapsed[0 +: 64]); else passed++;
    checks++; if (rx_pkt_cnt[0 +: 64] !== 64'd0) $display("[TB] FAIL pc_rx_pkt got %0d exp 0", rx_pkt_cnt[0 +: 64]); else passed++;
    checks++; if (lat_cnt[0 +: 64] !== 64'd0) $display("[TB] FAIL pc_lat_cnt got %0d exp 0", lat_cnt[0 +: 64]); else passed++;
    checks++; if (tx_pkt_cnt[128 +: 64] !== 64'd0) $display("[TB] FAIL pc_ch2_tx_pkt got %0d exp 0", tx_pkt_cnt[128 +: 64]); else passed++;
    checks++; if (snap_done !== 1'b1) $display("[TB] FAIL pc_snap_done got %0b exp 1", snap_done); else passed++;
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_ready_keep();
    test_overflow_underflow();
    test_bypass();
    test_clear_snap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/axis_mon_mc.md
# axis_mon_mc

Multi-channel AXI4-Stream traffic monitor, the next generation of the single-pair AXIS monitor. It passively taps NUM_CH independent TX/RX stream pairs and keeps per-channel packet, byte, elapsed-time and loopback-latency statistics. Per-channel latency uses a timestamp FIFO and reports sum, min and max. All statistics are presented through a coherent snapshot taken on request, so software never reads a torn 64-bit value. It sits beside the datapath under test, in the same place as the single-channel monitor.

## Interface
- NUM_CH, 4: number of monitored TX/RX pairs (1..16).
- DWIDTH, 64: tdata width in bits; multiple of 8.
- HAS_READY, 1: when 0, tready inputs are ignored and treated as 1.
- HAS_KEEP, 1: when 0, every beat counts DWIDTH/8 bytes.
- HAS_LAST, 1: when 0, every beat is a packet.
- TS_DEPTH, 16: timestamp FIFO depth per channel; power of 2, ≥2.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset; synchronous, active-low.
- clear  in  1  one-cycle pulse; synchronous clear of all state, same effect as reset.
- snap  in  1  one-cycle pulse; captures live statistics into output registers.
- tx_tvalid, tx_tready, tx_tlast  in  NUM_CH  per-channel TX tap.
- tx_tkeep  in  NUM_CH*DWIDTH/8  TX keep; channel c occupies slice c.
- rx_tvalid, rx_tready, rx_tlast, rx_tkeep  in  same widths as TX  RX tap.
- snap_done  out  1  pulses one cycle after snap.
- time_cnt  out  64  free-running cycle counter (live, not snapshotted).
- tx_pkt_cnt, tx_bytes, tx_elapsed  out  NUM_CH*64  per-channel TX statistics.
- rx_pkt_cnt, rx_bytes, rx_elapsed  out  NUM_CH*64  per-channel RX statistics.
- lat_sum  out  NUM_CH*64  per-channel latency sum.
- lat_cnt  out  NUM_CH*64  per-channel latency sample count.
- lat_min, lat_max  out  NUM_CH*32  per-channel latency extremes.
- ts_ovf, ts_unf  out  NUM_CH  sticky timestamp-FIFO overflow and underflow flags (live).

## Operation
Beat and packet events:
- A beat occurs when tvalid & (tready | !HAS_READY).
- A packet end occurs when beat & (tlast | !HAS_LAST).
- Beat bytes are popcount(tkeep) when HAS_KEEP, otherwise DWIDTH/8.

Counters:
- time_cnt increments every cycle.
- pkt_cnt increments on each packet end.
- bytes accumulates on each beat.
- All 64-bit counters wrap modulo 2^64.

Elapsed time:
- first_ts latches time_cnt at the first beat after reset or clear.
- last_ts latches time_cnt on every beat.
- elapsed = last_ts - first_ts + 1, or 0 if no beat has occurred.

Latency:
- A TX packet end pushes time_cnt[31:0] into the channel FIFO.
- An RX packet end pops the FIFO head; latency = time_cnt[31:0] - head, modulo 2^32.
- Each latency sample adds to lat_sum, increments lat_cnt and updates lat_min/lat_max.

FIFO boundary conditions:
- Push and pop in the same cycle with the FIFO empty: bypass path, latency 0.
- Push when full with no pop: entry dropped, ts_ovf set.
- Push when full with a simultaneous pop: both are performed.
- Pop when empty with no push: no latency sample, ts_unf set.

Reset, clear and snapshot:
- Reset or clear zeroes all counters, FIFOs, flags and outputs.
- lat_min resets to 0xFFFFFFFF, meaning no samples.
- clear and snap in the same cycle: clear wins, and outputs load reset values.
- No state machine; each channel is counters plus a FIFO.

## Timing
- All outputs are registered.
- On snap in cycle N, outputs take the live values including events of cycle N (next-state capture). They are valid from cycle N+1, with snap_done=1 in cycle N+1.
- Outputs hold between snaps.
- ts_ovf, ts_unf and time_cnt are live: updated the cycle after their causing event.
- Latency is measured handshake-to-handshake: a TX last at cycle T and an RX last at cycle T+k gives latency k.
- No input backpressure; the block never stalls.

## Structure
- Package axis_mon_mc_pkg holds:
  - localparams CNT_W=64 and TS_W=32;
  - LAT_MIN_INIT = '1;
  - a ch_stats_t struct (pkt, bytes, elapsed, lat_sum, lat_cnt, lat_min, lat_max);
  - a popcount function.
- Sub-module axis_mon_ch holds one channel's counters, timestamp FIFO and min/max logic. It is instantiated NUM_CH times in a generate loop.
- Top level holds time_cnt, the snapshot registers and output flattening.

## Test plan
- Reset then snap with no traffic → all counts 0, lat_min=0xFFFFFFFF, lat_max=0, snap_done one cycle later.
- Ch0: 3 TX packets of 4 beats each with tkeep=0xFF, looped back with 10-cycle delay → tx/rx pkt_cnt=3, bytes=96, lat_cnt=3, lat_sum=30, min=max=10.
- Ch1: tvalid high with tready toggling 1010, HAS_KEEP with tkeep=0x0F on the last beat → only ready beats counted, bytes=8·(full beats)+4.
- Ch2: TS_DEPTH+1 TX packets with no RX → ts_ovf=1. Then one RX with none pending after drain → ts_unf=1. Other channels unaffected.
- TX last and RX last on ch3 in the same cycle with the FIFO empty → lat_cnt=1, lat_sum=0, lat_min=0.
- Traffic running, then clear and snap in the same cycle → outputs all reset values. A subsequent snap reflects only post-clear traffic.
